// File: rtl/led_pkg.sv
// Shared definitions for the LED PWM driver.
//   LED_NUM_DEFAULT / LED_PWM_BITS_DEFAULT : default channel count and duty width
//   duty_t                                 : duty value at the default width
//   led_gamma()                            : square-law brightness curve, used when
//                                            the design is built with LED_GAMMA_EN
package led_pkg;

   localparam int LED_NUM_DEFAULT      = 8;
   localparam int LED_PWM_BITS_DEFAULT = 8;
   localparam int LED_MAX_BITS         = 16;

   typedef logic [LED_PWM_BITS_DEFAULT-1:0] duty_t;

   // f(d) = (d*d) >> bits, with full scale mapped to full scale so that a
   // maximum duty request stays at maximum brightness.
   // d is zero-extended into the 16-bit argument; bits is the live duty width.
   function automatic logic [LED_MAX_BITS-1:0] led_gamma(
      input logic [LED_MAX_BITS-1:0] d,
      input int unsigned             bits
   );
      logic [2*LED_MAX_BITS-1:0] prod;
      logic [LED_MAX_BITS-1:0]   full;
      full = LED_MAX_BITS'((32'd1 << bits) - 32'd1);
      prod = {{LED_MAX_BITS{1'b0}}, d} * {{LED_MAX_BITS{1'b0}}, d};
      if (d == full) begin
         return full;
      end
      return LED_MAX_BITS'(prod >> bits);
   endfunction

endpackage

// File: rtl/led_pwm_channel.sv
// One PWM channel: shadow duty register (host-written), active duty register
// (loaded only at the period boundary) and the registered LED output.
// Optional macro LED_GAMMA_EN: active <= led_gamma(shadow) instead of shadow.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   wr_stb     load shadow from wr_duty
//   wr_duty    duty value to store
//   boundary   last tick of the PWM period; shadow -> active
//   pwm_cnt    shared PWM counter
//   en         global output enable
//   led        registered PWM output
module led_pwm_channel
   import led_pkg::*;
#(
   parameter int PWM_BITS = LED_PWM_BITS_DEFAULT
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                wr_stb,
   input  logic [PWM_BITS-1:0] wr_duty,
   input  logic                boundary,
   input  logic [PWM_BITS-1:0] pwm_cnt,
   input  logic                en,
   output logic                led
);

   logic [PWM_BITS-1:0] shadow;
   logic [PWM_BITS-1:0] active;
   logic [PWM_BITS-1:0] next_active;

`ifdef LED_GAMMA_EN
   always_comb begin
      next_active = PWM_BITS'(led_gamma(LED_MAX_BITS'(shadow), int unsigned'(PWM_BITS)));
   end
`else
   always_comb begin
      next_active = shadow;
   end
`endif

   // Active only changes at the boundary, so a period already in progress is
   // never cut short or stretched by a host write.
   always_ff @(posedge clk) begin
      if (rst) begin
         shadow <= '0;
         active <= '0;
         led    <= 1'b0;
      end else begin
         if (wr_stb) begin
            shadow <= wr_duty;
         end
         if (boundary) begin
            active <= next_active;
         end
         led <= en && (pwm_cnt < active);
      end
   end

endmodule

// File: rtl/led_pwm_driver.sv
// Multi-channel LED brightness driver feeding the LED output IOBs.
// Host writes per-channel duty over a valid/ready port; each channel emits
// glitch-free PWM. Period = 2**PWM_BITS ticks, one tick every PRESCALE clocks.
// Optional macro LED_GAMMA_EN: applies a square-law curve to duty values.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   wr_valid      duty write request
//   wr_ready      write accept; low in reset and in the period-boundary cycle
//   wr_addr       channel index (indices >= NUM_LEDS are accepted and dropped)
//   wr_duty       requested duty
//   en            global output enable
//   leds          registered PWM outputs
//   period_start  one-cycle pulse aligned with pwm_cnt wrapping to 0
module led_pwm_driver
   import led_pkg::*;
#(
   parameter  int NUM_LEDS = LED_NUM_DEFAULT,
   parameter  int PWM_BITS = LED_PWM_BITS_DEFAULT,
   parameter  int PRESCALE = 64,
   localparam int AW       = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                wr_valid,
   output logic                wr_ready,
   input  logic [AW-1:0]       wr_addr,
   input  logic [PWM_BITS-1:0] wr_duty,
   input  logic                en,
   output logic [NUM_LEDS-1:0] leds,
   output logic                period_start
);

   localparam int               PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PS_W-1:0]  PS_LAST = PS_W'(PRESCALE - 1);

   logic [PS_W-1:0]     prescaler;
   logic [PWM_BITS-1:0] pwm_cnt;
   logic                tick;
   logic                boundary;
   logic                wr_fire;
   logic                addr_ok;
   logic [NUM_LEDS-1:0] wr_stb;

   assign tick     = (prescaler == PS_LAST);
   assign boundary = tick && (pwm_cnt == '1);

   // Stalling writes during the boundary keeps a write from landing in the
   // same cycle that shadow is copied to active.
   assign wr_ready = !rst && !boundary;
   assign wr_fire  = wr_valid && wr_ready;
   assign addr_ok  = (int'(wr_addr) < NUM_LEDS);

   always_ff @(posedge clk) begin
      if (rst) begin
         prescaler    <= '0;
         pwm_cnt      <= '0;
         period_start <= 1'b0;
      end else begin
         prescaler    <= tick ? '0 : prescaler + 1'b1;
         if (tick) begin
            pwm_cnt <= pwm_cnt + 1'b1;
         end
         period_start <= boundary;
      end
   end

   for (genvar i = 0; i < NUM_LEDS; i++) begin : g_ch
      assign wr_stb[i] = wr_fire && addr_ok && (wr_addr == AW'(i));

      led_pwm_channel #(
         .PWM_BITS (PWM_BITS)
      ) u_ch (
         .clk      (clk),
         .rst      (rst),
         .wr_stb   (wr_stb[i]),
         .wr_duty  (wr_duty),
         .boundary (boundary),
         .pwm_cnt  (pwm_cnt),
         .en       (en),
         .led      (leds[i])
      );
   end

endmodule

// File: tb/tb_led_pwm_driver.sv
// Bench for led_pwm_driver. Main instance: 6 channels (so indices 6 and 7 are
// out of range), PRESCALE=1, checked every cycle against a period-level model.
// Second instance: 8 channels, PRESCALE=4, checked for period length and duty.
module tb_led_pwm_driver;
   import led_pkg::*;

   localparam int NL = 6;

   logic        clk = 1'b0;
   logic        rst, wr_valid, en;
   logic        wr_ready, period_start;
   logic [2:0]  wr_addr;
   duty_t       wr_duty;
   logic [NL-1:0] leds;

   logic        rst4, wr_valid4, en4;
   logic        wr_ready4, period_start4;
   logic [2:0]  wr_addr4;
   logic [7:0]  wr_duty4;
   logic [7:0]  leds4;

   int n_checks = 0;
   int n_err    = 0;

   // Reference state: pwm position about to be sampled, per-channel duties.
   int   m_cnt;
   int   m_shadow[NL];
   int   m_active[NL];
   logic [NL-1:0] m_leds;
   logic m_ps;
   int   hi[NL];

   always #5 clk = ~clk;

   led_pwm_driver #(.NUM_LEDS(NL), .PWM_BITS(8), .PRESCALE(1)) dut (
      .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready),
      .wr_addr(wr_addr), .wr_duty(wr_duty), .en(en), .leds(leds),
      .period_start(period_start)
   );

   led_pwm_driver #(.NUM_LEDS(8), .PWM_BITS(8), .PRESCALE(4)) dut4 (
      .clk(clk), .rst(rst4), .wr_valid(wr_valid4), .wr_ready(wr_ready4),
      .wr_addr(wr_addr4), .wr_duty(wr_duty4), .en(en4), .leds(leds4),
      .period_start(period_start4)
   );

   initial begin
      #2_000_000;
      $display("FAIL watchdog got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic int f_model(input int d);
`ifdef LED_GAMMA_EN
      if (d == 255) return 255;
      return (d * d) / 256;
`else
      return d;
`endif
   endfunction

   // One clock: check wr_ready, advance the model with the inputs the DUT is
   // about to sample, then check the registered outputs after the edge.
   task automatic step();
      bit bnd;
      #2;
      check("wr_ready", 32'(wr_ready), 32'(!rst && m_cnt != 255));
      if (rst) begin
         m_cnt = 0;
         for (int i = 0; i < NL; i++) begin
            m_shadow[i] = 0;
            m_active[i] = 0;
         end
         m_leds = '0;
         m_ps   = 1'b0;
      end else begin
         bnd = (m_cnt == 255);
         for (int i = 0; i < NL; i++) m_leds[i] = en && (m_cnt < m_active[i]);
         if (bnd) begin
            for (int i = 0; i < NL; i++) m_active[i] = f_model(m_shadow[i]);
         end
         if (wr_valid && !bnd && int'(wr_addr) < NL) m_shadow[int'(wr_addr)] = int'(wr_duty);
         m_ps  = bnd;
         m_cnt = (m_cnt + 1) % 256;
      end
      @(posedge clk);
      #1;
      check("leds", 32'(leds), 32'(m_leds));
      check("period_start", 32'(period_start), 32'(m_ps));
   endtask

   task automatic write(input int addr, input int duty);
      bit acc = 1'b0;
      wr_valid = 1'b1;
      wr_addr  = 3'(addr);
      wr_duty  = 8'(duty);
      for (int k = 0; k < 4 && !acc; k++) begin
         #1;
         acc = wr_ready;
         step();
      end
      check("write_accept", 32'(acc), 32'd1);
      wr_valid = 1'b0;
   endtask

   // Sync to period_start, then count high cycles per channel over the next
   // full period (samples reflect pwm_cnt 0..255). Optional write at sample wr_at.
   task automatic run_period(input bit do_wr, input int wr_at, input int addr, input int duty);
      int k = 0;
      while (!period_start && k < 600) begin
         step();
         k++;
      end
      check("sync", 32'(k < 600), 32'd1);
      for (int i = 0; i < NL; i++) hi[i] = 0;
      for (int j = 0; j < 256; j++) begin
         if (do_wr && j == wr_at) begin
            wr_valid = 1'b1;
            wr_addr  = 3'(addr);
            wr_duty  = 8'(duty);
         end else begin
            wr_valid = 1'b0;
         end
         step();
         for (int i = 0; i < NL; i++) hi[i] += int'(leds[i]);
      end
      wr_valid = 1'b0;
      check("period_len", 32'(period_start), 32'd1);
   endtask

   task automatic step_until_cnt(input int c);
      int k = 0;
      while (m_cnt != c && k < 300) begin
         step();
         k++;
      end
      check("cnt_reach", 32'(m_cnt), 32'(c));
   endtask

   initial begin
      int k, gap, h0, h3;
      bit acc;
      rst = 1'b1; wr_valid = 1'b1; wr_addr = 3'd1; wr_duty = 8'd200; en = 1'b1;
      rst4 = 1'b1; wr_valid4 = 1'b0; wr_addr4 = '0; wr_duty4 = '0; en4 = 1'b1;
      m_cnt = 0; m_leds = '0; m_ps = 1'b0;
      for (int i = 0; i < NL; i++) begin m_shadow[i] = 0; m_active[i] = 0; end

      // Reset with a write pending: nothing taken, outputs quiet.
      repeat (3) step();
      check("rst_leds", 32'(leds), 32'd0);
      rst = 1'b0;
      wr_valid = 1'b0;
      run_period(1'b0, 0, 0, 0);
      check("post_rst_ch1", 32'(hi[1]), 32'd0);

      // Basic duties.
      write(0, 0);
      write(1, 128);
      write(2, 255);
      run_period(1'b0, 0, 0, 0);
      check("duty_ch0", 32'(hi[0]), 32'(f_model(0)));
      check("duty_ch1", 32'(hi[1]), 32'(f_model(128)));
      check("duty_ch2", 32'(hi[2]), 32'(f_model(255)));

      // Mid-period write affects only the following period.
      run_period(1'b1, 40, 1, 32);
      check("midwr_cur", 32'(hi[1]), 32'(f_model(128)));
      run_period(1'b0, 0, 0, 0);
      check("midwr_next", 32'(hi[1]), 32'(f_model(32)));

      // Write held across the boundary cycle.
      step_until_cnt(255);
      wr_valid = 1'b1; wr_addr = 3'd2; wr_duty = 8'd64;
      #1;
      check("bnd_stall", 32'(wr_ready), 32'd0);
      step();
      check("bnd_ready_next", 32'(wr_ready), 32'd1);
      step();
      wr_valid = 1'b0;
      run_period(1'b0, 0, 0, 0);
      check("bnd_applied", 32'(hi[2]), 32'(f_model(64)));

      // Out-of-range addresses complete the handshake and change nothing.
      write(6, 99);
      write(7, 11);
      run_period(1'b0, 0, 0, 0);
      check("oor_ch0", 32'(hi[0]), 32'd0);
      check("oor_ch1", 32'(hi[1]), 32'(f_model(32)));
      check("oor_ch2", 32'(hi[2]), 32'(f_model(64)));

      // Enable drop mid-period.
      step_until_cnt(10);
      en = 1'b0;
      step();
      check("en_off", 32'(leds), 32'd0);
      repeat (5) step();
      en = 1'b1;
      repeat (5) step();

      // Randomized traffic, including boundary writes, enable and reset.
      for (int n = 0; n < 4000; n++) begin
         wr_valid = ($urandom % 4) == 0;
         wr_addr  = 3'($urandom % 8);
         case ($urandom % 8)
            0:       wr_duty = 8'd0;
            1:       wr_duty = 8'd255;
            default: wr_duty = 8'($urandom);
         endcase
         if (($urandom % 200) == 0) en = ~en;
         rst = ($urandom % 1500) == 0;
         step();
      end
      rst = 1'b0; wr_valid = 1'b0; en = 1'b1;

      // Prescaled instance.
      rst4 = 1'b0;
      wr_valid4 = 1'b1; wr_addr4 = 3'd3; wr_duty4 = 8'd128;
      acc = 1'b0;
      for (int t = 0; t < 4 && !acc; t++) begin #1; acc = wr_ready4; step(); end
      check("p4_wr3", 32'(acc), 32'd1);
      wr_addr4 = 3'd0; wr_duty4 = 8'd255;
      acc = 1'b0;
      for (int t = 0; t < 4 && !acc; t++) begin #1; acc = wr_ready4; step(); end
      check("p4_wr0", 32'(acc), 32'd1);
      wr_valid4 = 1'b0;
      k = 0;
      while (!period_start4 && k < 3000) begin step(); k++; end
      check("p4_sync", 32'(k < 3000), 32'd1);
      gap = 0; h0 = 0; h3 = 0;
      do begin
         step();
         gap++;
         h0 += int'(leds4[0]);
         h3 += int'(leds4[3]);
      end while (!period_start4 && gap < 3000);
      check("p4_period", 32'(gap), 32'd1024);
      check("p4_duty3", 32'(h3), 32'(4 * f_model(128)));
      check("p4_duty0", 32'(h0), 32'(4 * f_model(255)));

      // Reset mid-period, then confirm the counters restarted from zero.
      repeat (300) step();
      rst4 = 1'b1;
      #1;
      check("p4_rst_ready", 32'(wr_ready4), 32'd0);
      step();
      check("p4_rst_leds", 32'(leds4), 32'd0);
      check("p4_rst_ps", 32'(period_start4), 32'd0);
      rst4 = 1'b0;
      k = 0;
      h3 = 0;
      do begin
         step();
         k++;
         h3 += int'(leds4[3]);
      end while (!period_start4 && k < 3000);
      check("p4_restart", 32'(k), 32'd1024);
      check("p4_duty_lost", 32'(h3), 32'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
      $finish;
   end

endmodule
